// File: rtl/rs_encoder_pkg.sv
// Shared constants, state encoding and GF(8) index/polynomial conversions
// for the RS(7,5) encoder. Symbols are in index form: 0 = zero, k = alpha^(k-1).
package rs_encoder_pkg;

  localparam int SYMBOL_WIDTH = 3;
  localparam int N            = 7;
  localparam int K            = 5;
  localparam int CNT_W        = 3;

  typedef logic [SYMBOL_WIDTH-1:0] sym_t;

  localparam sym_t G1_IDX = 3'd5;
  localparam sym_t G0_IDX = 3'd4;

  localparam logic [CNT_W-1:0] LAST_CNT = 3'd4;

  typedef enum logic [1:0] {
    MSG   = 2'd0,
    PAR1  = 2'd1,
    PAR0  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Index form to polynomial bit vector over x^3+x+1.
  function automatic sym_t idx_to_poly(input sym_t idx);
    sym_t p;
    case (idx)
      3'd0:    p = 3'b000;
      3'd1:    p = 3'b001;
      3'd2:    p = 3'b010;
      3'd3:    p = 3'b100;
      3'd4:    p = 3'b011;
      3'd5:    p = 3'b110;
      3'd6:    p = 3'b111;
      3'd7:    p = 3'b101;
      default: p = 3'b000;
    endcase
    return p;
  endfunction

  function automatic sym_t poly_to_idx(input sym_t p);
    sym_t idx;
    case (p)
      3'b000:  idx = 3'd0;
      3'b001:  idx = 3'd1;
      3'b010:  idx = 3'd2;
      3'b100:  idx = 3'd3;
      3'b011:  idx = 3'd4;
      3'b110:  idx = 3'd5;
      3'b111:  idx = 3'd6;
      3'b101:  idx = 3'd7;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/GF_Adder.sv
// GF(8) addition of two index-form symbols (XOR in polynomial form).
module GF_Adder
  import rs_encoder_pkg::*;
(
  input  logic [SYMBOL_WIDTH-1:0] a_i,
  input  logic [SYMBOL_WIDTH-1:0] b_i,
  output logic [SYMBOL_WIDTH-1:0] sum_o
);

  assign sum_o = poly_to_idx(idx_to_poly(a_i) ^ idx_to_poly(b_i));

endmodule

// File: rtl/GF_Multiplier.sv
// GF(8) multiplication of two index-form symbols: exponents add modulo 7,
// and the zero element absorbs.
module GF_Multiplier
  import rs_encoder_pkg::*;
(
  input  logic [SYMBOL_WIDTH-1:0] a_i,
  input  logic [SYMBOL_WIDTH-1:0] b_i,
  output logic [SYMBOL_WIDTH-1:0] prod_o
);

  int exp_s;

  always_comb begin
    exp_s = (int'(a_i) + int'(b_i) - 2) % 7;
    if ((a_i == 3'd0) || (b_i == 3'd0)) begin
      prod_o = 3'd0;
    end else begin
      prod_o = SYMBOL_WIDTH'(exp_s + 1);
    end
  end

endmodule

// File: rtl/rs_parity_lfsr.sv
// Two-stage generator-polynomial LFSR for g(x) = x^2 + a^4 x + a^3.
// The next-state values are exported so the top can latch final parity early.
module rs_parity_lfsr
  import rs_encoder_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    shift,
  input  logic                    clear,
  input  logic [SYMBOL_WIDTH-1:0] m,
  output logic [SYMBOL_WIDTH-1:0] r1,
  output logic [SYMBOL_WIDTH-1:0] r0,
  output logic [SYMBOL_WIDTH-1:0] r1_nxt,
  output logic [SYMBOL_WIDTH-1:0] r0_nxt
);

  sym_t r1_q, r0_q;
  sym_t fb_s, g1f_s;

  GF_Adder u_add_fb (.a_i(m), .b_i(r1_q), .sum_o(fb_s));
  GF_Multiplier u_mul_g1 (.a_i(G1_IDX), .b_i(fb_s), .prod_o(g1f_s));
  GF_Multiplier u_mul_g0 (.a_i(G0_IDX), .b_i(fb_s), .prod_o(r0_nxt));
  GF_Adder u_add_r1 (.a_i(r0_q), .b_i(g1f_s), .sum_o(r1_nxt));

  // Parity state: clear dominates shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_q <= 3'd0;
      r0_q <= 3'd0;
    end else if (clear) begin
      r1_q <= 3'd0;
      r0_q <= 3'd0;
    end else if (shift) begin
      r1_q <= r1_nxt;
      r0_q <= r0_nxt;
    end
  end

  assign r1 = r1_q;
  assign r0 = r0_q;

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(7,5) encoder: serial message in, serial codeword out through a
// single-stage output register, plus a parallel codeword bus flagged by cw_rdy.
module rs_encoder
  import rs_encoder_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [SYMBOL_WIDTH-1:0]   in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [SYMBOL_WIDTH-1:0]   out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [N*SYMBOL_WIDTH-1:0] codeword,
  output logic                      cw_rdy
);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          sym_cnt_q, sym_cnt_d;
  sym_t                      out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [N*SYMBOL_WIDTH-1:0] codeword_q, codeword_d;
  logic                      cw_rdy_q, cw_rdy_d;

  logic       slot_free_s, in_ready_s, shift_s, clear_s;
  logic [4:0] slot_base_s;
  sym_t       r1_s, r0_s, r1_nxt_s, r0_nxt_s;

  rs_parity_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .shift  (shift_s),
    .clear  (clear_s),
    .m      (in_data),
    .r1     (r1_s),
    .r0     (r0_s),
    .r1_nxt (r1_nxt_s),
    .r0_nxt (r0_nxt_s)
  );

  assign slot_free_s = !out_valid_q || out_ready;
  assign slot_base_s = 5'((N - 1 - int'(sym_cnt_q)) * SYMBOL_WIDTH);

  // Next-state, handshake and codeword assembly.
  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q;
    codeword_d  = codeword_q;
    cw_rdy_d    = 1'b0;
    in_ready_s  = 1'b0;
    shift_s     = 1'b0;
    clear_s     = 1'b0;

    case (state_q)
      MSG: begin
        in_ready_s = slot_free_s;
        if (in_valid && slot_free_s) begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          shift_s     = 1'b1;
          codeword_d[slot_base_s +: SYMBOL_WIDTH] = in_data;
          if (sym_cnt_q == LAST_CNT) begin
            // Parity lands on the bus together with the final message symbol.
            state_d   = PAR1;
            sym_cnt_d = 3'd0;
            cw_rdy_d  = 1'b1;
            codeword_d[SYMBOL_WIDTH +: SYMBOL_WIDTH] = r1_nxt_s;
            codeword_d[0 +: SYMBOL_WIDTH]            = r0_nxt_s;
          end else begin
            sym_cnt_d = sym_cnt_q + 3'd1;
          end
        end else begin
          sym_cnt_d = sym_cnt_q;
        end
      end
      PAR1: begin
        if (slot_free_s) begin
          out_data_d  = r1_s;
          out_valid_d = 1'b1;
          state_d     = PAR0;
        end else begin
          state_d = PAR1;
        end
      end
      PAR0: begin
        if (slot_free_s) begin
          out_data_d  = r0_s;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          state_d     = DRAIN;
        end else begin
          state_d = PAR0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          clear_s     = 1'b1;
          state_d     = MSG;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = MSG;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MSG;
      sym_cnt_q   <= 3'd0;
      out_data_q  <= 3'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      codeword_q  <= 21'd0;
      cw_rdy_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      codeword_q  <= codeword_d;
      cw_rdy_q    <= cw_rdy_d;
    end
  end

  assign in_ready  = in_ready_s && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign codeword  = codeword_q;
  assign cw_rdy    = cw_rdy_q;

endmodule
